// File: rtl/adc_avm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_avm_sequencer
//  Description : Avalon-MM host that configures the ADC board register block,
//                reads channel A/B sample pairs and shuts the ADC down again.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_avm_sequencer #(
    parameter int CNT_W        = 16,
    parameter int READ_LATENCY = 1,
    parameter int GAP_CYCLES   = 0
) (
    input  logic             main_clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       cfg_gain_a,
    input  logic [1:0]       cfg_gain_b,
    input  logic             cfg_sig_en,
    input  logic             cfg_sig_freq,
    input  logic [1:0]       cfg_led_mode,
    input  logic [CNT_W-1:0] num_samples,
    output logic             busy,
    output logic             done,
    output logic             sample_valid,
    output logic [7:0]       sample_cha,
    output logic [7:0]       sample_chb,
    output logic [3:0]       address,
    output logic             read,
    output logic             write,
    output logic [7:0]       writedata,
    input  logic [7:0]       readdata
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CFG    = 4'd1;
    localparam logic [3:0] S_RD_A   = 4'd2;
    localparam logic [3:0] S_WAIT_A = 4'd3;
    localparam logic [3:0] S_RD_B   = 4'd4;
    localparam logic [3:0] S_WAIT_B = 4'd5;
    localparam logic [3:0] S_GAP    = 4'd6;
    localparam logic [3:0] S_OFF    = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    localparam int               LAT_IDX   = READ_LATENCY - 1;
    localparam logic [1:0]       WAIT_LAST = 2'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [3:0]              state_q, state_d;
    logic [2:0]              step_q, step_d;
    logic [1:0]              wcnt_q, wcnt_d;
    logic [CNT_W-1:0]        gcnt_q, gcnt_d;
    logic [CNT_W-1:0]        rem_q, rem_d;
    logic [1:0]              ga_q, ga_d, gb_q, gb_d, led_q, led_d;
    logic                    se_q, se_d, sf_q, sf_d;
    logic [7:0]              hold_q, hold_d;
    // Read-in-flight tracker: bit i set means a read strobe was issued i+1
    // cycles ago; chan_q records which channel (address bit 0) it targeted.
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;
    logic [READ_LATENCY-1:0] chan_q, chan_d;
    logic                    busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic [7:0]              cha_q, cha_d, chb_q, chb_d;
    logic [3:0]              addr_q, addr_d;
    logic                    rd_q, rd_d, wr_q, wr_d;
    logic [7:0]              wd_q, wd_d;

    // Next-state logic: sequencing, bus strobes and readdata capture
    always_comb begin
        state_d = state_q;  step_d = step_q;  wcnt_d = wcnt_q;
        gcnt_d  = gcnt_q;   rem_d  = rem_q;   hold_d = hold_q;
        ga_d    = ga_q;     gb_d   = gb_q;    led_d  = led_q;
        se_d    = se_q;     sf_d   = sf_q;
        busy_d  = busy_q;   done_d = 1'b0;    valid_d = 1'b0;
        cha_d   = cha_q;    chb_d  = chb_q;
        addr_d  = addr_q;   wd_d   = wd_q;    rd_d = 1'b0;  wr_d = 1'b0;

        pipe_d[0] = rd_q;
        chan_d[0] = addr_q[0];
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
            chan_d[i] = chan_q[i-1];
        end

        // readdata is valid exactly READ_LATENCY cycles after the strobe
        if (pipe_q[LAT_IDX]) begin
            if (!chan_q[LAT_IDX]) begin
                hold_d = readdata;
            end else begin
                cha_d   = hold_q;
                chb_d   = readdata;
                valid_d = 1'b1;
                rem_d   = rem_q - ONE;
            end
        end

        case (state_q)
            S_IDLE: begin
                // done_q high means the DONE cycle is still showing; ignore start
                if (start && !done_q) begin
                    ga_d    = cfg_gain_a;
                    gb_d    = cfg_gain_b;
                    se_d    = cfg_sig_en;
                    sf_d    = cfg_sig_freq;
                    led_d   = cfg_led_mode;
                    rem_d   = num_samples;
                    busy_d  = 1'b1;
                    step_d  = 3'd0;
                    state_d = S_CFG;
                end
            end
            S_CFG: begin
                wr_d   = 1'b1;
                step_d = step_q + 3'd1;
                case (step_q)
                    3'd0:    begin addr_d = 4'd4; wd_d = {6'd0, ga_q};  end
                    3'd1:    begin addr_d = 4'd5; wd_d = {6'd0, gb_q};  end
                    3'd2:    begin addr_d = 4'd6; wd_d = {7'd0, se_q};  end
                    3'd3:    begin addr_d = 4'd7; wd_d = {7'd0, sf_q};  end
                    3'd4:    begin addr_d = 4'd8; wd_d = {6'd0, led_q}; end
                    default: begin
                        addr_d  = 4'd1;
                        wd_d    = 8'd1;
                        state_d = (rem_q == '0) ? S_OFF : S_RD_A;
                    end
                endcase
            end
            S_RD_A: begin
                rd_d    = 1'b1;
                addr_d  = 4'd2;
                wcnt_d  = 2'd0;
                state_d = S_WAIT_A;
            end
            S_WAIT_A: begin
                if (wcnt_q == WAIT_LAST) state_d = S_RD_B;
                else                     wcnt_d  = wcnt_q + 2'd1;
            end
            S_RD_B: begin
                rd_d    = 1'b1;
                addr_d  = 4'd3;
                wcnt_d  = 2'd0;
                state_d = S_WAIT_B;
            end
            S_WAIT_B: begin
                if (wcnt_q != WAIT_LAST) begin
                    wcnt_d = wcnt_q + 2'd1;
                end else if (rem_q == ONE || abort) begin
                    // The pair just read has not been counted yet, hence ONE
                    state_d = S_OFF;
                end else if (GAP_CYCLES == 0) begin
                    state_d = S_RD_A;
                end else begin
                    gcnt_d  = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gcnt_q == GAP_LAST) state_d = S_RD_A;
                else                    gcnt_d  = gcnt_q + ONE;
            end
            S_OFF: begin
                // Let the last pair land before switching the ADC off
                if (pipe_q == '0 && !rd_q) begin
                    wr_d    = 1'b1;
                    addr_d  = 4'd1;
                    wd_d    = 8'd0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge main_clk) begin
        if (rst) begin
            state_q <= S_IDLE; step_q <= '0; wcnt_q <= '0; gcnt_q <= '0; rem_q <= '0;
            ga_q <= '0; gb_q <= '0; led_q <= '0; se_q <= 1'b0; sf_q <= 1'b0;
            hold_q <= '0; pipe_q <= '0; chan_q <= '0;
            busy_q <= 1'b0; done_q <= 1'b0; valid_q <= 1'b0;
            cha_q <= '0; chb_q <= '0; addr_q <= '0; rd_q <= 1'b0; wr_q <= 1'b0; wd_q <= '0;
        end else begin
            state_q <= state_d; step_q <= step_d; wcnt_q <= wcnt_d; gcnt_q <= gcnt_d; rem_q <= rem_d;
            ga_q <= ga_d; gb_q <= gb_d; led_q <= led_d; se_q <= se_d; sf_q <= sf_d;
            hold_q <= hold_d; pipe_q <= pipe_d; chan_q <= chan_d;
            busy_q <= busy_d; done_q <= done_d; valid_q <= valid_d;
            cha_q <= cha_d; chb_q <= chb_d; addr_q <= addr_d; rd_q <= rd_d; wr_q <= wr_d; wd_q <= wd_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign sample_valid = valid_q;
    assign sample_cha   = cha_q;
    assign sample_chb   = chb_q;
    assign address      = addr_q;
    assign read         = rd_q;
    assign write        = wr_q;
    assign writedata    = wd_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_avm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_avm_sequencer
//  Description : Scoreboard bench for adc_avm_sequencer (default timing DUT
//                plus a READ_LATENCY=3 / GAP_CYCLES=5 DUT).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_avm_sequencer;

    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          start0, abort0, se0, sf0, busy0, done0, sv0, rd0, wr0;
    logic [1:0]    ga0, gb0, led0;
    logic [CW-1:0] num0;
    logic [7:0]    cha0, chb0, wd0, rdata0;
    logic [3:0]    addr0;

    logic          start1, abort1, se1, sf1, busy1, done1, sv1, rd1, wr1;
    logic [1:0]    ga1, gb1, led1;
    logic [CW-1:0] num1;
    logic [7:0]    cha1, chb1, wd1, rdata1;
    logic [3:0]    addr1;

    adc_avm_sequencer #(.CNT_W(CW), .READ_LATENCY(1), .GAP_CYCLES(0)) u_dut0 (
        .main_clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .cfg_gain_a(ga0), .cfg_gain_b(gb0), .cfg_sig_en(se0), .cfg_sig_freq(sf0),
        .cfg_led_mode(led0), .num_samples(num0), .busy(busy0), .done(done0),
        .sample_valid(sv0), .sample_cha(cha0), .sample_chb(chb0), .address(addr0),
        .read(rd0), .write(wr0), .writedata(wd0), .readdata(rdata0)
    );

    adc_avm_sequencer #(.CNT_W(CW), .READ_LATENCY(3), .GAP_CYCLES(5)) u_dut1 (
        .main_clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .cfg_gain_a(ga1), .cfg_gain_b(gb1), .cfg_sig_en(se1), .cfg_sig_freq(sf1),
        .cfg_led_mode(led1), .num_samples(num1), .busy(busy1), .done(done1),
        .sample_valid(sv1), .sample_cha(cha1), .sample_chb(chb1), .address(addr1),
        .read(rd1), .write(wr1), .writedata(wd1), .readdata(rdata1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Expected bus writes {addr,data} and sample pairs {cha,chb}
    logic [11:0] wq0[$];
    logic [15:0] sq0[$];
    logic [15:0] sq1[$];

    // Responder for DUT0: one-cycle registered readdata, 0xFF when idle.
    // k-th read of addr 2 returns 0x11*k, of addr 3 returns 0x22*k.
    int ka0, kb0;
    always @(posedge clk) begin
        if (rst || (wr0 && addr0 == 4'd4)) begin
            ka0 <= 1; kb0 <= 1; rdata0 <= 8'hFF;
        end else if (rd0 && addr0 == 4'd2) begin
            rdata0 <= 8'(ka0 * 17); ka0 <= ka0 + 1;
        end else if (rd0 && addr0 == 4'd3) begin
            rdata0 <= 8'(kb0 * 34); kb0 <= kb0 + 1;
        end else begin
            rdata0 <= 8'hFF;
        end
    end

    // Responder for DUT1: three-stage pipeline, data only on the valid cycle
    int ka1, kb1;
    logic [7:0] p1, p2, p3;
    always @(posedge clk) begin
        if (rst || (wr1 && addr1 == 4'd4)) begin
            ka1 <= 1; kb1 <= 1; p1 <= 8'hFF; p2 <= 8'hFF; p3 <= 8'hFF;
        end else begin
            p2 <= p1; p3 <= p2;
            if (rd1 && addr1 == 4'd2) begin
                p1 <= 8'(ka1 * 17); ka1 <= ka1 + 1;
            end else if (rd1 && addr1 == 4'd3) begin
                p1 <= 8'(kb1 * 34); kb1 <= kb1 + 1;
            end else begin
                p1 <= 8'hFF;
            end
        end
    end
    assign rdata1 = p3;

    // DUT0 monitor
    int cyc0 = 0, busy_cnt0 = 0, rd_cnt0 = 0, wr_cnt0 = 0, sv_cnt0 = 0, done_cnt0 = 0;
    int prev_sv0 = 0, wr_first0 = 0, wr_last0 = 0, done_cyc0 = 0;
    bit have_prev0 = 1'b0;
    always @(negedge clk) begin : mon0
        logic [11:0] ew;
        logic [15:0] es;
        cyc0++;
        if (!rst) begin
            if (busy0) busy_cnt0++;
            if (rd0 || wr0) check("rd_wr_exclusive", {31'd0, rd0 & wr0}, 32'd0);
            if (rd0) rd_cnt0++;
            if (wr0) begin
                wr_cnt0++;
                if (wq0.size() == 0) begin
                    check("unexpected_write", {20'd0, addr0, wd0}, 32'hFFFF);
                end else begin
                    ew = wq0.pop_front();
                    check("write_addr_data", {20'd0, addr0, wd0}, {20'd0, ew});
                    if (ew == {4'd4, 8'(ew[7:0])}) wr_first0 = cyc0;
                    if (ew == {4'd1, 8'd0}) begin
                        wr_last0 = cyc0;
                        check("samples_before_off", sq0.size(), 0);
                    end
                end
            end
            if (sv0) begin
                sv_cnt0++;
                if (sq0.size() == 0) begin
                    check("unexpected_sample", {16'd0, cha0, chb0}, 32'hFFFF_FFFF);
                end else begin
                    es = sq0.pop_front();
                    check("sample_pair", {16'd0, cha0, chb0}, {16'd0, es});
                end
                if (have_prev0) check("sample_spacing", cyc0 - prev_sv0, 4);
                prev_sv0   = cyc0;
                have_prev0 = 1'b1;
            end
            if (done0) begin
                done_cnt0++;
                done_cyc0 = cyc0;
                check("done_busy_low", {31'd0, busy0}, 32'd0);
                have_prev0 = 1'b0;
            end
        end
    end

    // DUT1 monitor
    int cyc1 = 0, wr_cnt1 = 0, sv_cnt1 = 0, done_cnt1 = 0, prev_sv1 = 0;
    bit have_prev1 = 1'b0;
    always @(negedge clk) begin : mon1
        logic [15:0] es;
        cyc1++;
        if (!rst) begin
            if (wr1) wr_cnt1++;
            if (sv1) begin
                sv_cnt1++;
                if (sq1.size() == 0) begin
                    check("unexpected_sample_lat", {16'd0, cha1, chb1}, 32'hFFFF_FFFF);
                end else begin
                    es = sq1.pop_front();
                    check("sample_pair_lat", {16'd0, cha1, chb1}, {16'd0, es});
                end
                if (have_prev1) check("sample_spacing_lat", cyc1 - prev_sv1, 13);
                prev_sv1   = cyc1;
                have_prev1 = 1'b1;
            end
            if (done1) have_prev1 = 1'b0;
            if (done1) done_cnt1++;
        end
    end

    task automatic start_seq0(input logic [1:0] ga, input logic [1:0] gb, input logic se,
                              input logic sf, input logic [1:0] led, input int n,
                              input int nexp, input bit off);
        ga0 = ga; gb0 = gb; se0 = se; sf0 = sf; led0 = led; num0 = CW'(n);
        wq0.push_back({4'd4, 6'd0, ga});
        wq0.push_back({4'd5, 6'd0, gb});
        wq0.push_back({4'd6, 7'd0, se});
        wq0.push_back({4'd7, 7'd0, sf});
        wq0.push_back({4'd8, 6'd0, led});
        wq0.push_back({4'd1, 8'd1});
        for (int k = 1; k <= nexp; k++) sq0.push_back({8'(k * 17), 8'(k * 34)});
        if (off) wq0.push_back({4'd1, 8'd0});
        start0 = 1'b1;
        @(negedge clk); #1;
        start0 = 1'b0;
    endtask

    task automatic wait_done0(input string tag);
        int d0 = done_cnt0;
        int i  = 0;
        while (done_cnt0 == d0 && i < 2000) begin
            @(negedge clk); #1;
            i++;
        end
        check(tag, {31'd0, done_cnt0 != d0}, 32'd1);
    endtask

    task automatic check_outputs_reset0(input string tag);
        check({tag, "_busy"}, {31'd0, busy0}, 32'd0);
        check({tag, "_done"}, {31'd0, done0}, 32'd0);
        check({tag, "_valid"}, {31'd0, sv0}, 32'd0);
        check({tag, "_read"}, {31'd0, rd0}, 32'd0);
        check({tag, "_write"}, {31'd0, wr0}, 32'd0);
        check({tag, "_address"}, {28'd0, addr0}, 32'd0);
        check({tag, "_writedata"}, {24'd0, wd0}, 32'd0);
        check({tag, "_cha"}, {24'd0, cha0}, 32'd0);
        check({tag, "_chb"}, {24'd0, chb0}, 32'd0);
    endtask

    initial begin
        int b, r, w, s, i;
        rst = 1'b1;
        start0 = 1'b0; abort0 = 1'b0; ga0 = '0; gb0 = '0; se0 = 1'b0; sf0 = 1'b0; led0 = '0; num0 = '0;
        start1 = 1'b0; abort1 = 1'b0; ga1 = '0; gb1 = '0; se1 = 1'b0; sf1 = 1'b0; led1 = '0; num1 = '0;
        repeat (3) @(negedge clk);
        #1;
        check_outputs_reset0("reset");
        rst = 1'b0;
        @(negedge clk); #1;

        // Configuration only, zero samples
        b = busy_cnt0; r = rd_cnt0;
        start_seq0(2'd2, 2'd1, 1'b1, 1'b0, 2'd1, 0, 0, 1'b1);
        wait_done0("cfg_done_timeout");
        check("cfg_busy_cycles", busy_cnt0 - b, 8);
        check("cfg_reads", rd_cnt0 - r, 0);
        check("cfg_write_span", wr_last0 - wr_first0, 6);
        check("cfg_done_after_off", done_cyc0 - wr_last0, 1);
        check("cfg_writes_left", wq0.size(), 0);
        @(negedge clk); #1;

        // Three sample pairs
        r = rd_cnt0; s = sv_cnt0;
        start_seq0(2'd0, 2'd2, 1'b0, 1'b1, 2'd2, 3, 3, 1'b1);
        wait_done0("cap_done_timeout");
        check("cap_pulses", sv_cnt0 - s, 3);
        check("cap_reads", rd_cnt0 - r, 6);
        check("cap_samples_left", sq0.size(), 0);
        check("cap_writes_left", wq0.size(), 0);
        @(negedge clk); #1;

        // Abort during the second pair
        s = sv_cnt0;
        start_seq0(2'd1, 2'd1, 1'b1, 1'b1, 2'd0, 100, 2, 1'b1);
        i = 0;
        while (sv_cnt0 == s && i < 200) begin
            @(negedge clk); #1;
            i++;
        end
        check("abort_first_pulse_timeout", {31'd0, sv_cnt0 != s}, 32'd1);
        abort0 = 1'b1;
        wait_done0("abort_done_timeout");
        abort0 = 1'b0;
        check("abort_pulses", sv_cnt0 - s, 2);
        check("abort_writes_left", wq0.size(), 0);
        @(negedge clk); #1;

        // Start pulses while busy, and in the DONE cycle, are ignored
        start_seq0(2'd1, 2'd2, 1'b0, 1'b1, 2'd2, 2, 2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            ga0 = 2'd3; gb0 = 2'd3; se0 = 1'b1; sf0 = 1'b0; led0 = 2'd0; num0 = CW'(7);
            start0 = 1'b1;
            @(negedge clk); #1;
            start0 = 1'b0;
            @(negedge clk); #1;
        end
        wait_done0("busy_done_timeout");
        ga0 = 2'd3; gb0 = 2'd0; se0 = 1'b1; sf0 = 1'b1; led0 = 2'd1; num0 = CW'(5);
        start0 = 1'b1;
        @(negedge clk); #1;
        start_seq0(2'd0, 2'd1, 1'b1, 1'b0, 2'd2, 1, 1, 1'b1);
        check("restart_busy", {31'd0, busy0}, 32'd1);
        wait_done0("restart_done_timeout");
        check("restart_writes_left", wq0.size(), 0);
        check("restart_samples_left", sq0.size(), 0);
        @(negedge clk); #1;

        // Reset while waiting on the channel B read
        start_seq0(2'd2, 2'd2, 1'b1, 1'b1, 2'd1, 5, 0, 1'b0);
        i = 0;
        while (!(rd0 && addr0 == 4'd3) && i < 100) begin
            @(negedge clk); #1;
            i++;
        end
        check("reach_wait_b", {31'd0, rd0 && addr0 == 4'd3}, 32'd1);
        rst = 1'b1;
        @(negedge clk); #1;
        check_outputs_reset0("midrst");
        rst = 1'b0;
        w = wr_cnt0; r = rd_cnt0;
        repeat (20) @(negedge clk);
        #1;
        check("midrst_no_writes", wr_cnt0 - w, 0);
        check("midrst_no_reads", rd_cnt0 - r, 0);
        check("midrst_writes_left", wq0.size(), 0);
        sq0.delete();

        // Idle after reset: a fresh start is accepted
        start_seq0(2'd1, 2'd0, 1'b0, 1'b0, 2'd0, 1, 1, 1'b1);
        wait_done0("post_rst_done_timeout");
        check("post_rst_samples_left", sq0.size(), 0);
        check("post_rst_writes_left", wq0.size(), 0);

        // Long read latency plus inter-pair gap
        w = wr_cnt1; s = sv_cnt1;
        sq1.push_back({8'h11, 8'h22});
        sq1.push_back({8'h22, 8'h44});
        num1 = CW'(2);
        start1 = 1'b1;
        @(negedge clk); #1;
        start1 = 1'b0;
        check("lat_busy", {31'd0, busy1}, 32'd1);
        i = 0;
        while (done_cnt1 == 0 && i < 500) begin
            @(negedge clk); #1;
            i++;
        end
        check("lat_done_timeout", {31'd0, done_cnt1 != 0}, 32'd1);
        check("lat_pulses", sv_cnt1 - s, 2);
        check("lat_writes", wr_cnt1 - w, 7);
        check("lat_samples_left", sq1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_avm_sequencer.md
Name: adc_avm_sequencer

Overview:
- Avalon-MM host (initiator) that drives the ADC board register block over its 8-bit, 4-bit-address register port.
- On a start pulse it:
  - writes the gain, signal-generator and LED-mode configuration,
  - enables the ADC,
  - reads channel A/B data registers for a programmed number of sample pairs,
  - disables the ADC.
- Sits between a host-side control block (or Nios-less test logic) and the register block, in the main_clk domain.

Parameters:
- CNT_W, 16, width of sample-count and gap counters.
- READ_LATENCY, 1, cycles from read assertion to valid readdata (responder registers readdata); legal range 1-4.
- GAP_CYCLES, 0, idle cycles inserted between consecutive sample pairs.

Ports:
- main_clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to run a sequence; ignored while busy=1.
- abort  in  1  level; ends the sampling phase early (clean shutdown).
- cfg_gain_a  in  2  channel A gain code (0:2x, 1:3.5x, 2:8.5x).
- cfg_gain_b  in  2  channel B gain code (same encoding).
- cfg_sig_en  in  1  onboard signal generator enable.
- cfg_sig_freq  in  1  signal generator frequency (0:2.5 MHz, 1:5 MHz).
- cfg_led_mode  in  2  LED source (0:register, 1:ch A, 2:ch B).
- num_samples  in  CNT_W  sample pairs to read; captured on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at sequence end.
- sample_valid  out  1  one-cycle pulse when sample_cha/sample_chb are updated.
- sample_cha  out  8  last channel A byte read (address 2).
- sample_chb  out  8  last channel B byte read (address 3).
- address  out  4  Avalon-MM address.
- read  out  1  Avalon-MM read strobe.
- write  out  1  Avalon-MM write strobe.
- writedata  out  8  Avalon-MM write data.
- readdata  in  8  Avalon-MM read data.

Behaviour:
- Reset values:
  - busy, done, sample_valid, read, write = 0.
  - address, writedata = 0.
  - sample_cha, sample_chb = 0.
  - FSM = IDLE; counters cleared.
- Reset mid-sequence aborts immediately with the same values. No shutdown write is issued.
- All outputs are registered. read and write are never high in the same cycle. Each strobe is high for exactly one cycle per transfer; there is no waitrequest.
- IDLE:
  - On start=1, latch all cfg_* inputs and num_samples into internal registers. busy rises next cycle.
  - Go to CFG.
- CFG: six back-to-back write cycles, one per clock, with zero-extended writedata:
  - addr 4 = gain_a
  - addr 5 = gain_b
  - addr 6 = sig_en
  - addr 7 = sig_freq
  - addr 8 = led_mode
  - addr 1 = 1 (ADC on)
- After CFG:
  - If the latched count is 0, go to OFF.
  - Otherwise go to RD_A.
- RD_A: read=1 with address=2 for one cycle, then WAIT_A.
- WAIT_A:
  - Wait READ_LATENCY cycles after the read cycle.
  - Capture readdata into a holding register on the cycle it is valid (cycle READ_LATENCY after the strobe).
  - Then go to RD_B.
- RD_B / WAIT_B: same as RD_A / WAIT_A with address=3.
  - On capture, update sample_cha (from the holding register) and sample_chb together.
  - Pulse sample_valid in the following cycle.
  - Decrement the remaining count.
- Minimum pair period is 2*(1+READ_LATENCY) cycles; with defaults that is 4 cycles.
- After each pair:
  - If the remaining count is 0 or abort=1, go to OFF.
  - Otherwise spend GAP_CYCLES in GAP, then go to RD_A.
- abort is sampled only at pair boundaries. An in-flight pair always completes and is reported.
- abort in CFG is ignored.
- OFF: one write, addr 1 = 0 (ADC off), then DONE.
- DONE:
  - done=1 for one cycle, busy=0 in that same cycle, return to IDLE.
  - A start in the DONE cycle is ignored. A start in the following IDLE cycle is accepted.
- Count arithmetic:
  - The count is unsigned CNT_W bits.
  - num_samples = 2^CNT_W-1 is legal and yields that many pairs.
  - There is no wrap-around.
- address and writedata hold their last value when no strobe is active.
- readdata is ignored outside capture cycles.

Test Plan:
- Config sequence:
  - Stimulus: after rst, start with gain_a=2, gain_b=1, sig_en=1, sig_freq=0, led_mode=1, num_samples=0.
  - Required response: writes (4,2), (5,1), (6,1), (7,0), (8,1), (1,1), (1,0) on 7 consecutive cycles; done pulse; zero reads; total busy = 8 cycles.
- Sample capture:
  - Stimulus: num_samples=3; responder model returns addr2 = 0x11·k and addr3 = 0x22·k for k = 1..3.
  - Required response:
    - 3 sample_valid pulses with (0x11,0x22), (0x22,0x44), (0x33,0x66);
    - pulses spaced 4 cycles apart;
    - final write (1,0).
- Latency/gap:
  - Stimulus: READ_LATENCY=3, GAP_CYCLES=5, num_samples=2; responder drives readdata only on the valid cycle, 0xFF otherwise.
  - Required response: correct bytes captured (no 0xFF); sample_valid pulses 13 cycles apart.
- Abort:
  - Stimulus: num_samples=100, assert abort during the 2nd pair.
  - Required response: exactly 2 sample_valid pulses, then write (1,0), then done.
- Busy protection:
  - Stimulus: pulse start repeatedly during an active sequence.
  - Required response: no restart, configuration unchanged.
  - Stimulus: start during the DONE cycle. Required response: ignored.
  - Stimulus: start one cycle later. Required response: new sequence begins.
- Reset mid-operation:
  - Stimulus: assert rst while in WAIT_B.
  - Required response: next cycle all outputs are at reset values, the FSM is in IDLE, and no further strobes occur.
